// File: rtl/l2_pkg.sv
// Shared definitions for the L2 port responder: FSM state encoding,
// request-kind encoding and page geometry constants.
package l2_pkg;

    localparam int unsigned L2_LINE_WORDS = 4;
    localparam int unsigned L2_LINE_OFS_W = 2;
    localparam int unsigned L2_WORD_W     = 32;
    localparam int unsigned L2_PAGE_W     = L2_WORD_W * L2_LINE_WORDS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_WR_REQ,
        ST_RD_DONE,
        ST_WR_DONE,
        ST_GAP
    } state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_e;

endpackage

// File: rtl/l2_port_responder_snoop_fifo.sv
// Synchronous FIFO holding peer-write addresses until they can be
// forwarded to the L1 as invalidations.
//   push/push_data : enqueue (dropped when full unless a pop frees a slot)
//   pop/pop_data   : dequeue request / head entry (ignored when empty)
//   count/full/empty : occupancy status
module snoop_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // Pop only what was stored before this cycle, so a push into an
        // empty FIFO is never popped in the same cycle.
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = store_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/l2_port_responder.sv
// L2-side responder for one L1 cache port.
//   c_l2_*     : L1 request in, page refill / write ack out
//   mem_*      : word-wide backing store, req held until ack
//   peer_wr_*  : writes committed by other ports (buffered, forwarded as c_dirty)
//   snoop_wr_* : broadcast of this port's committed writes
//   c_dirty*   : invalidate pulses to the L1
module l2_port_responder
    import l2_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LINE_WORDS  = L2_LINE_WORDS,
    parameter int unsigned SNOOP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         c_l2_valid,
    input  logic                         c_l2_rd_wr,
    input  logic [ADDR_W-1:0]            c_l2_addr,
    input  logic [DATA_W-1:0]            c_l2_din,
    output logic                         c_l2_page_wr,
    output logic [DATA_W*LINE_WORDS-1:0] c_l2_page_dout,
    output logic                         c_l2_wr_ack,
    output logic                         c_dirty,
    output logic [ADDR_W-1:0]            c_dirty_addr,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack,
    input  logic                         peer_wr_valid,
    input  logic [ADDR_W-1:0]            peer_wr_addr,
    output logic                         peer_wr_full,
    output logic                         snoop_wr_valid,
    output logic [ADDR_W-1:0]            snoop_wr_addr
);

    localparam int unsigned LINE_W = ADDR_W - L2_LINE_OFS_W;
    localparam int unsigned PAGE_W = DATA_W * LINE_WORDS;
    localparam int unsigned CNT_W  = $clog2(SNOOP_DEPTH) + 1;
    localparam logic [L2_LINE_OFS_W-1:0] LAST_BEAT = L2_LINE_OFS_W'(LINE_WORDS - 1);

    state_e                     state_q, state_d;
    logic [LINE_W-1:0]          line_q, line_d;
    logic [L2_LINE_OFS_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          din_q, din_d;
    logic [PAGE_W-1:0]          page_q, page_d;
    logic                       mem_req_q, mem_req_d;
    logic                       mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]          mem_wdata_q, mem_wdata_d;
    logic                       page_wr_q, page_wr_d;
    logic                       wr_ack_q, wr_ack_d;
    logic                       snoop_valid_q, snoop_valid_d;
    logic [ADDR_W-1:0]          snoop_addr_q, snoop_addr_d;
    logic                       dirty_q, dirty_d;
    logic [ADDR_W-1:0]          dirty_addr_q, dirty_addr_d;

    logic                       fifo_pop;
    logic [ADDR_W-1:0]          fifo_data;
    logic [CNT_W-1:0]           fifo_count;
    logic                       fifo_full, fifo_empty;

    snoop_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (SNOOP_DEPTH)
    ) u_snoop_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (peer_wr_valid),
        .push_data (peer_wr_addr),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        din_d   = din_q;
        page_d  = page_q;

        case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                if (c_l2_valid) begin
                    if (c_l2_rd_wr == REQ_WR) begin
                        addr_d  = c_l2_addr;
                        din_d   = c_l2_din;
                        state_d = ST_WR_REQ;
                    end else begin
                        line_d  = c_l2_addr[ADDR_W-1:L2_LINE_OFS_W];
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (mem_ack) begin
                    for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                        if (beat_q == L2_LINE_OFS_W'(k)) page_d[k*DATA_W +: DATA_W] = mem_rdata;
                    end
                    if (beat_q == LAST_BEAT) state_d = ST_RD_DONE;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            ST_WR_REQ:  if (mem_ack) state_d = ST_WR_DONE;
            ST_RD_DONE: state_d = ST_GAP;
            ST_WR_DONE: state_d = ST_GAP;
            ST_GAP:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // yet line up with the state they describe.
        mem_req_d     = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
        mem_we_d      = (state_d == ST_WR_REQ);
        mem_addr_d    = '0;
        if (state_d == ST_RD_REQ) mem_addr_d = {line_d, beat_d};
        if (state_d == ST_WR_REQ) mem_addr_d = addr_d;
        mem_wdata_d   = (state_d == ST_WR_REQ) ? din_d : '0;
        page_wr_d     = (state_d == ST_RD_DONE);
        wr_ack_d      = (state_d == ST_WR_DONE);
        snoop_valid_d = (state_d == ST_WR_DONE);
        snoop_addr_d  = (state_d == ST_WR_DONE) ? addr_d : '0;

        // Gating on the next state holds invalidates through the whole
        // refill including the page_wr cycle; the first one lands in GAP.
        fifo_pop      = !fifo_empty && (state_d != ST_RD_REQ) && (state_d != ST_RD_DONE);
        dirty_d       = fifo_pop;
        dirty_addr_d  = fifo_pop ? fifo_data : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            line_q        <= '0;
            beat_q        <= '0;
            addr_q        <= '0;
            din_q         <= '0;
            page_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            page_wr_q     <= 1'b0;
            wr_ack_q      <= 1'b0;
            snoop_valid_q <= 1'b0;
            snoop_addr_q  <= '0;
            dirty_q       <= 1'b0;
            dirty_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            beat_q        <= beat_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            page_q        <= page_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            page_wr_q     <= page_wr_d;
            wr_ack_q      <= wr_ack_d;
            snoop_valid_q <= snoop_valid_d;
            snoop_addr_q  <= snoop_addr_d;
            dirty_q       <= dirty_d;
            dirty_addr_q  <= dirty_addr_d;
        end
    end

    occupancy_bounded: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= CNT_W'(SNOOP_DEPTH));

    assign c_l2_page_wr   = page_wr_q;
    assign c_l2_page_dout = page_q;
    assign c_l2_wr_ack    = wr_ack_q;
    assign c_dirty        = dirty_q;
    assign c_dirty_addr   = dirty_addr_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign peer_wr_full   = fifo_full;
    assign snoop_wr_valid = snoop_valid_q;
    assign snoop_wr_addr  = snoop_addr_q;

endmodule

// File: tb/tb_l2_port_responder.sv
// Scoreboard bench for l2_port_responder: stimulus pushes expected
// page/ack/invalidate/memory-op records; a negedge monitor pops and compares.
module tb_l2_port_responder;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int PW = DW * LW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_l2_valid, c_l2_rd_wr;
    logic [AW-1:0] c_l2_addr;
    logic [DW-1:0] c_l2_din;
    logic          c_l2_page_wr;
    logic [PW-1:0] c_l2_page_dout;
    logic          c_l2_wr_ack, c_dirty;
    logic [AW-1:0] c_dirty_addr;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ack;
    logic          peer_wr_valid;
    logic [AW-1:0] peer_wr_addr;
    logic          peer_wr_full, snoop_wr_valid;
    logic [AW-1:0] snoop_wr_addr;

    l2_port_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .LINE_WORDS  (LW),
        .SNOOP_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .c_l2_valid     (c_l2_valid),
        .c_l2_rd_wr     (c_l2_rd_wr),
        .c_l2_addr      (c_l2_addr),
        .c_l2_din       (c_l2_din),
        .c_l2_page_wr   (c_l2_page_wr),
        .c_l2_page_dout (c_l2_page_dout),
        .c_l2_wr_ack    (c_l2_wr_ack),
        .c_dirty        (c_dirty),
        .c_dirty_addr   (c_dirty_addr),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .peer_wr_valid  (peer_wr_valid),
        .peer_wr_addr   (peer_wr_addr),
        .peer_wr_full   (peer_wr_full),
        .snoop_wr_valid (snoop_wr_valid),
        .snoop_wr_addr  (snoop_wr_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [PW-1:0] exp_page[$];
    logic [AW-1:0] exp_wr[$];
    logic [AW-1:0] exp_dirty[$];
    mem_op_t       exp_mem[$];
    int            lat_q[$];

    logic [DW-1:0] store   [0:(1<<AW)-1];  // backing store seen by the DUT
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];  // reference contents
    bit            in_refill = 0;
    bit            rand_lat  = 0;
    bit            rand_run  = 0;
    int            req_drop  = 0;
    int            ack_cnt   = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    function automatic logic [PW-1:0] outs_nonpage();
        return PW'({mem_req, mem_we, mem_addr, mem_wdata, c_l2_page_wr, c_l2_wr_ack,
                    c_dirty, c_dirty_addr, peer_wr_full, snoop_wr_valid, snoop_wr_addr});
    endfunction

    // Backing store: ack arrives (extra latency + 1) cycles after a request starts.
    initial begin
        int wait_c;
        bit busy;
        mem_ack = 0; mem_rdata = '0; busy = 0; wait_c = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                mem_ack = 0; busy = 0;
                continue;
            end
            if (mem_ack) begin
                mem_ack = 0; busy = 0; mem_rdata = DW'($urandom);
            end
            if (busy) begin
                if (!mem_req) begin
                    req_drop++; busy = 0;
                end else begin
                    wait_c--;
                    if (wait_c == 0) begin
                        mem_ack = 1; ack_cnt++;
                        if (mem_we) store[mem_addr] = mem_wdata;
                        else        mem_rdata = store[mem_addr];
                    end
                end
            end else if (mem_req) begin
                busy = 1;
                if (lat_q.size() > 0) wait_c = lat_q.pop_front() + 1;
                else if (rand_lat)    wait_c = $urandom_range(0, 3) + 1;
                else                  wait_c = 1;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            if (mem_ack) begin
                if (exp_mem.size() == 0) fail_now("mem_unexpected");
                else begin
                    mem_op_t op;
                    op = exp_mem.pop_front();
                    check("mem_req_at_ack", mem_req, 1'b1);
                    check("mem_we", mem_we, op.we);
                    check("mem_addr", mem_addr, op.addr);
                    if (op.we) check("mem_wdata", mem_wdata, op.wdata);
                end
            end
            if (c_l2_page_wr) begin
                if (exp_page.size() == 0) fail_now("page_unexpected");
                else check("page_dout", c_l2_page_dout, exp_page.pop_front());
                in_refill = 0;
            end
            if (c_l2_wr_ack || snoop_wr_valid) begin
                check("wr_ack_snoop_pair", {c_l2_wr_ack, snoop_wr_valid}, 2'b11);
                if (exp_wr.size() == 0) fail_now("wr_unexpected");
                else check("snoop_wr_addr", snoop_wr_addr, exp_wr.pop_front());
            end
            if (c_dirty) begin
                check("dirty_not_during_refill", in_refill, 1'b0);
                if (exp_dirty.size() == 0) fail_now("dirty_unexpected");
                else check("c_dirty_addr", c_dirty_addr, exp_dirty.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit chk_lat);
        logic [PW-1:0] pg;
        logic [AW-1:0] base, ad;
        int n;
        bit seen;
        base = a & ~AW'(3);
        for (int k = 0; k < LW; k++) begin
            ad = base + AW'(k);
            pg[k*DW +: DW] = ref_mem[ad];
            exp_mem.push_back('{we: 1'b0, addr: ad, wdata: '0});
        end
        exp_page.push_back(pg);
        c_l2_rd_wr = 0; c_l2_addr = a; c_l2_din = DW'($urandom); c_l2_valid = 1;
        n = 0; seen = 0;
        while (!seen && n < 300) begin
            @(posedge clk); #1; n++;
            if (n == 1) in_refill = 1;
            if (c_l2_page_wr) seen = 1;
        end
        c_l2_valid = 0;
        if (!seen) begin fail_now("read_timeout"); in_refill = 0; end
        if (chk_lat) check("read_latency", n, 9);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bit seen;
        ref_mem[a] = d;
        exp_mem.push_back('{we: 1'b1, addr: a, wdata: d});
        exp_wr.push_back(a);
        c_l2_rd_wr = 1; c_l2_addr = a; c_l2_din = d; c_l2_valid = 1;
        n = 0; seen = 0;
        while (!seen && n < 300) begin
            @(posedge clk); #1; n++;
            if (c_l2_wr_ack) seen = 1;
        end
        c_l2_valid = 0;
        if (!seen) fail_now("write_timeout");
        else check("mem_req_dropped_after_ack", mem_req, 1'b0);
    endtask

    task automatic push_peer(input logic [AW-1:0] a);
        if (!peer_wr_full) begin
            peer_wr_valid = 1; peer_wr_addr = a; exp_dirty.push_back(a);
        end
        @(posedge clk); #1;
        peer_wr_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base_ack, n;
        for (int i = 0; i < (1 << AW); i++) begin
            store[i] = DW'(i); ref_mem[i] = DW'(i);
        end
        rst = 0; c_l2_valid = 0; c_l2_rd_wr = 0; c_l2_addr = '0; c_l2_din = '0;
        peer_wr_valid = 0; peer_wr_addr = '0;
        #12;
        check("reset_outputs", outs_nonpage(), '0);
        check("reset_page", c_l2_page_dout, '0);
        @(negedge clk); rst = 1;
        idle(2);

        // Directed refill, 1-cycle memory
        do_read(14'h0105, 1);
        @(posedge clk); #1;
        check("page_wr_one_cycle", c_l2_page_wr, 1'b0);
        idle(1);

        // Directed write
        do_write(14'h0022, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("wr_ack_one_cycle", c_l2_wr_ack, 1'b0);
        idle(1);

        // Variable memory latency
        lat_q = '{0, 3, 7, 1};
        do_read(AW'($urandom), 0);
        idle(2);

        // Peer write during refill
        fork
            do_read(14'h0104, 0);
            begin idle(2); push_peer(14'h0104); end
        join
        @(posedge clk); #1;
        check("dirty_in_gap", c_dirty, 1'b1);
        check("dirty_in_gap_addr", c_dirty_addr, 14'h0104);
        @(posedge clk); #1;
        check("dirty_single_pulse", c_dirty, 1'b0);
        idle(2);

        // Fill the snoop FIFO during a refill
        fork
            do_read(AW'($urandom), 0);
            begin
                idle(2);
                for (int i = 0; i < 4; i++) push_peer(14'h0200 + AW'(i));
                check("full_after_4", peer_wr_full, 1'b1);
            end
        join
        @(posedge clk); #1;
        check("drain_dirty_0", c_dirty, 1'b1);
        check("full_clears_after_pop", peer_wr_full, 1'b0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check("drain_dirty_consecutive", c_dirty, 1'b1);
        end
        idle(2);

        // Reset in the middle of beat 2
        lat_q = '{2, 2, 2, 2};
        for (int k = 0; k < LW; k++)
            exp_mem.push_back('{we: 1'b0, addr: 14'h0300 + AW'(k), wdata: '0});
        c_l2_rd_wr = 0; c_l2_addr = 14'h0301; c_l2_valid = 1;
        base_ack = ack_cnt; n = 0;
        while (ack_cnt < base_ack + 2 && n < 100) begin @(posedge clk); #1; n++; end
        check("reset_test_reached_beat2", ack_cnt - base_ack, 2);
        @(posedge clk); #2;
        rst = 0;
        #1;
        check("midop_reset_outputs", outs_nonpage(), '0);
        check("midop_reset_page", c_l2_page_dout, '0);
        c_l2_valid = 0;
        exp_mem.delete(); lat_q.delete();
        idle(2);
        @(negedge clk); rst = 1;
        idle(15);
        do_read(14'h0301, 1);
        idle(2);

        // Randomized traffic with concurrent peer writes
        rand_lat = 1; rand_run = 1;
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    if ($urandom_range(0, 1) == 0) do_read(AW'($urandom), 0);
                    else do_write(AW'($urandom), DW'($urandom));
                    @(posedge clk); #1;
                    idle(1 + $urandom_range(0, 2));
                end
                rand_run = 0;
            end
            begin
                while (rand_run) begin
                    if ($urandom_range(0, 3) == 0) push_peer(AW'($urandom));
                    else idle(1);
                end
            end
        join
        rand_lat = 0;
        idle(12);

        check("pending_pages", exp_page.size(), 0);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_dirty", exp_dirty.size(), 0);
        check("pending_mem_ops", exp_mem.size(), 0);
        check("mem_req_held_between_acks", req_drop, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
